regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the fixed 32×32, 2-read/1-write register file. Adds configurable width, depth, read-port and write-port counts, deterministic post-reset clearing of every register through an internal clear sequencer, and optional write-to-read bypass. Sits between decode (read addresses) and writeback (write ports) and feeds operands to the execute stage.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of registers; power of two, minimum 4
- NRD, 2, number of read ports, 1..4
- NWR, 1, number of write ports, 1..2
- ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register
- AW, derived = log2(NREGS), address width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- rd_addr  input  NRD*AW  packed read addresses; port i occupies [i*AW +: AW]
- rd_data  output  NRD*XLEN  packed read data; port i occupies [i*XLEN +: XLEN]
- wr_en  input  NWR  per-port write enable
- wr_addr  input  NWR*AW  packed write addresses
- wr_data  input  NWR*XLEN  packed write data
- ready  output  1  high when the clear sequence has finished and writes are accepted

## Operation
- FSM states: CLEAR, RUN.
- reset high at a rising edge: state <= CLEAR, clr_cnt <= 0, ready <= 0. Register contents are not touched on that edge.
- CLEAR: each cycle writes 0 to register clr_cnt, then clr_cnt increments. On the cycle that clears NREGS-1, next state is RUN and ready <= 1. The sequence takes exactly NREGS cycles.
- During CLEAR:
  - wr_en is ignored and no user write lands.
  - every rd_data port returns 0.
- RUN, write port k with wr_en[k]=1 writes wr_data[k] to wr_addr[k] at the rising edge.
- ZERO_REG=1: writes to address 0 are dropped and reads of address 0 return 0.
- Two write ports targeting the same address in the same cycle: port NWR-1 wins. The lower port's write is discarded.
- Reads are combinational from array contents (plus bypass if enabled). Out-of-range addresses cannot occur because AW matches NREGS exactly.
- Reset asserted mid-CLEAR restarts the sequence at clr_cnt=0. Reset asserted in RUN re-enters CLEAR.
- clr_cnt is AW+1 bits wide to avoid wrap-around when NREGS is a power of two.

## Timing
- Reset values: ready=0, state=CLEAR, clr_cnt=0. rd_data=0 throughout CLEAR.
- Reset deasserted after cycle T: ready rises at the edge ending cycle T+NREGS. The first user write is accepted in cycle T+NREGS+1.
- Read latency is 0 cycles (combinational from address).
- Write latency is 1 edge. Without bypass, a read in the same cycle as a write to the same address returns the old value, and the new value is visible the next cycle.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, a read address matching an enabled write address in the same cycle returns that write's data combinationally.
  - If both write ports match, port NWR-1 data is returned.
  - Address 0 with ZERO_REG=1 is never bypassed and still returns 0.
  - No bypass occurs during CLEAR.
- REGFILE_BYPASS_EN undefined: no bypass muxes are built, and same-cycle reads return the pre-write value.

## Test plan
- Hold reset 3 cycles, release, with NREGS=32: ready stays 0 for 32 cycles then goes 1. All 32 registers read 0 on every read port. Writes attempted during CLEAR (addr 5, data 32'hDEAD_BEEF) leave register 5 at 0.
- RUN, write addr 7 = 32'h0000_0009, next cycle read port 0 addr 7, port 1 addr 0 with ZERO_REG=1: port 0 = 32'h0000_0009, port 1 = 0. Write addr 0 = 32'h1234 then read addr 0: returns 0.
- NWR=2, both ports write addr 3 (port 0 = 32'hAAAA_AAAA, port 1 = 32'h5555_5555): addr 3 reads 32'h5555_5555 the next cycle.
- Same-cycle write addr 4 = 32'h0000_0006 with a read of addr 4 (old value 0): returns 32'h0000_0006 with REGFILE_BYPASS_EN defined and 0 without it. The next cycle returns 32'h0000_0006 in both builds.
- Write addr 2 = 32'h50, assert reset at clr_cnt=10 of a later CLEAR, release: ready rises NREGS cycles after release (not earlier), and addr 2 reads 0.
- ZERO_REG=0, NREGS=8, XLEN=16: write addr 0 = 16'hBEEF reads back 16'hBEEF, and the clear sequence takes exactly 8 cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with post-reset clear sequencer
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  output logic                 ready
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     clr_cnt_q, clr_cnt_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [XLEN-1:0] rd_val;
  logic            clr_last;

  assign clr_last = (clr_cnt_q == (AW+1)'(NREGS - 1));
  assign ready    = ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Array has no reset; the clear sequencer zeroes it after reset instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + (AW+1)'(1);
        if (clr_last) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    ready_d = (state_d == RUN);
  end

  always_comb begin
    mem_d = mem_q;
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem_d[clr_cnt_q[AW-1:0]] = '0;
      end else begin
        // Ascending port order lets the highest port win on an address clash.
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && !(ZERO_REG != 0 && wr_addr[k*AW +: AW] == '0))
            mem_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
        end
      end
    end

    rd_val  = '0;
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_val = mem_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++) begin
        if (state_q == RUN && wr_en[k] && wr_addr[k*AW +: AW] == rd_addr[i*AW +: AW])
          rd_val = wr_data[k*XLEN +: XLEN];
      end
`endif
      if (state_q == CLEAR || (ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0))
        rd_val = '0;
      rd_data[i*XLEN +: XLEN] = rd_val;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (main 32x32 2R/2W and small 8x16 ZERO_REG=0)
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        ready;

  logic        reset_s = 1'b1;
  logic [2:0]  rd_addr_s = '0;
  logic [15:0] rd_data_s;
  logic [0:0]  wr_en_s = '0;
  logic [2:0]  wr_addr_s = '0;
  logic [15:0] wr_data_s = '0;
  logic        ready_s;

  int total = 0;
  int bad = 0;

  logic [31:0] model [32];
  bit          running = 0;
  int          clr_left = 32;

  string       sb_tag [$];
  logic [31:0] sb_exp [$];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready)
  );

  regfile_mp #(.XLEN(16), .NREGS(8), .NRD(1), .NWR(1), .ZERO_REG(0)) dut_s (
    .clk(clk), .reset(reset_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s), .ready(ready_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic sb_pop_chk(input logic [31:0] got);
    if (sb_exp.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      check(sb_tag.pop_front(), got, sb_exp.pop_front());
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input logic we0, input logic [4:0] wa0,
                                         input logic [31:0] wd0, input logic we1, input logic [4:0] wa1,
                                         input logic [31:0] wd1);
    logic [31:0] v;
    if (!running || ra == 5'd0) return 32'd0;
    v = model[ra];
`ifdef REGFILE_BYPASS_EN
    if (we0 && wa0 == ra) v = wd0;
    if (we1 && wa1 == ra) v = wd1;
`else
    if (we0 && we1 && wa0 == 5'd31 && wa1 == 5'd31 && wd0 == wd1) v = v;
`endif
    return v;
  endfunction

  // One main-DUT cycle: drive, predict, sample at negedge, advance, update model.
  task automatic cyc(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                     input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                     input logic [4:0] ra0, input logic [4:0] ra1, input string tag);
    wr_en   = {we1, we0};
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0};
    sb_push({tag, ".rd0"}, exp_rd(ra0, we0, wa0, wd0, we1, wa1, wd1));
    sb_push({tag, ".rd1"}, exp_rd(ra1, we0, wa0, wd0, we1, wa1, wd1));
    sb_push({tag, ".ready"}, {31'd0, running});
    @(negedge clk);
    sb_pop_chk(rd_data[31:0]);
    sb_pop_chk(rd_data[63:32]);
    sb_pop_chk({31'd0, ready});
    @(posedge clk);
    #1;
    if (reset) begin
      running  = 0;
      clr_left = 32;
    end else if (running) begin
      if (we0 && wa0 != 5'd0) model[wa0] = wd0;
      if (we1 && wa1 != 5'd0) model[wa1] = wd1;
    end else begin
      clr_left--;
      if (clr_left == 0) begin
        running = 1;
        for (int r = 0; r < 32; r++) model[r] = '0;
      end
    end
    wr_en = '0;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1, input string tag);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra0, ra1, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) model[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    running  = 0;
    clr_left = 32;

    // Clear phase: user writes to 5 must be ignored, every read is 0, ready low.
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), $sformatf("clr%0d", i));
    for (int i = 0; i < 32; i++)
      idle(5'(i), 5'(31 - i), $sformatf("zero%0d", i));

    cyc(1'b1, 5'd7, 32'h0000_0009, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, "w7");
    idle(5'd7, 5'd0, "r7");
    cyc(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7, "w0");
    idle(5'd0, 5'd0, "r0");

    cyc(1'b1, 5'd3, 32'hAAAA_AAAA, 1'b1, 5'd3, 32'h5555_5555, 5'd3, 5'd1, "w3both");
    idle(5'd3, 5'd3, "r3");

    cyc(1'b1, 5'd4, 32'h0000_0006, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0, "w4byp");
    idle(5'd4, 5'd7, "r4");
    cyc(1'b1, 5'd9, 32'h0000_0011, 1'b1, 5'd9, 32'h0000_0022, 5'd9, 5'd4, "w9byp");
    idle(5'd9, 5'd9, "r9");

    cyc(1'b1, 5'd2, 32'h0000_0050, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, "w2");
    idle(5'd2, 5'd7, "r2");

    // Reset in RUN, then again at clr_cnt=10 of that clear sequence.
    reset = 1'b1;
    idle(5'd2, 5'd3, "rst_run");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) idle(5'd2, 5'd7, $sformatf("clrA%0d", i));
    reset = 1'b1;
    idle(5'd2, 5'd7, "rst_mid");
    reset = 1'b0;
    for (int i = 0; i < 32; i++) idle(5'd2, 5'(i), $sformatf("clrB%0d", i));
    idle(5'd2, 5'd7, "after_clr");
    idle(5'd3, 5'd9, "after_clr2");

    // Small instance: ZERO_REG=0, NREGS=8, XLEN=16.
    reset_s = 1'b1;
    @(posedge clk);
    #1;
    reset_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb_push($sformatf("s_clr%0d.ready", i), 32'd0);
      @(negedge clk);
      sb_pop_chk({31'd0, ready_s});
      @(posedge clk);
      #1;
    end
    sb_push("s_done.ready", 32'd1);
    @(negedge clk);
    sb_pop_chk({31'd0, ready_s});
    @(posedge clk);
    #1;
    wr_en_s   = 1'b1;
    wr_addr_s = 3'd0;
    wr_data_s = 16'hBEEF;
    rd_addr_s = 3'd0;
    @(posedge clk);
    #1;
    wr_en_s = 1'b0;
    sb_push("s_r0", 32'h0000_BEEF);
    @(negedge clk);
    sb_pop_chk({16'd0, rd_data_s});

    check("sb_drained", sb_exp.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
